// File: rtl/fetch_sequencer.sv
// Program-sequencing controller for the simple_cpu instruction memory bus.
// Owns the program counter, a small hardware return-address stack and a
// terminal HALT state. All outputs come straight from registers or from the
// state register, so there is no combinational path from inputs to outputs.

module fetch_sequencer #(
  parameter int unsigned AW          = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         stall,
  input  logic                         jump,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         halt_req,
  input  logic [AW-1:0]                target,
  output logic                         im_abus_valid,
  output logic [AW-1:0]                im_abus_data,
  output logic                         halted,
  output logic                         stack_err,
  output logic [$clog2(STACK_DEPTH):0] depth
);

  localparam int unsigned IW = $clog2(STACK_DEPTH);
  localparam int unsigned DW = IW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   sp_q, sp_d;
  logic            err_q, err_d;
  logic            push;
  logic [AW-1:0]   pc_inc;
  logic [AW-1:0]   top_entry;
  logic [AW-1:0]   stack_q [STACK_DEPTH];

  assign pc_inc    = pc_q + AW'(1);
  // Only meaningful when sp_q > 0; the ret path checks that before using it.
  assign top_entry = stack_q[IW'(sp_q - DW'(1))];

  // Next-state logic: priority halt_req > stall > !run > ret > call > jump > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StRun;
      end
      StRun: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (stall) begin
          // Freeze everything; control inputs are dropped, not queued.
        end else if (!run) begin
          state_d = StIdle;
        end else if (ret) begin
          if (sp_q != '0) begin
            pc_d = top_entry;
            sp_d = sp_q - DW'(1);
          end else begin
            err_d   = 1'b1;
            state_d = StHalt;
          end
        end else if (call) begin
          if (sp_q < DW'(STACK_DEPTH)) begin
            push = 1'b1;
            pc_d = target;
            sp_d = sp_q + DW'(1);
          end else begin
            err_d   = 1'b1;
            state_d = StHalt;
          end
        end else if (jump) begin
          pc_d = target;
        end else begin
          pc_d = pc_inc;
        end
      end
      StHalt: begin
        // Terminal until reset.
      end
      default: state_d = StIdle;
    endcase
  end

  // State, PC, stack pointer and sticky error register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage; contents survive reset, only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (push && !reset) stack_q[IW'(sp_q)] <= pc_inc;
  end

  // Outputs decoded from registered state only.
  always_comb begin
    im_abus_valid = (state_q == StRun);
    halted        = (state_q == StHalt);
    im_abus_data  = pc_q;
    stack_err     = err_q;
    depth         = sp_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by a
// randomized run, all compared against an abstract model (integer PC, queue
// used as the return stack, simple mode flag).

module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, stall, jump, call, ret, halt_req;
  logic [7:0] target;
  logic       im_abus_valid, halted, stack_err;
  logic [7:0] im_abus_data;
  logic [2:0] depth;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = idle, 1 = fetching, 2 = halted.
  int m_mode;
  int m_pc;
  int m_stack[$];
  bit m_err;

  always #5 clk = ~clk;

  fetch_sequencer #(.AW(8), .STACK_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .stall         (stall),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .halt_req      (halt_req),
    .target        (target),
    .im_abus_valid (im_abus_valid),
    .im_abus_data  (im_abus_data),
    .halted        (halted),
    .stack_err     (stack_err),
    .depth         (depth)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit r, input bit s, input bit j, input bit c, input bit rt,
                        input bit h, input logic [7:0] t);
    run = r; stall = s; jump = j; call = c; ret = rt; halt_req = h; target = t;
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_pc = 0; m_err = 0;
      m_stack.delete();
    end else if (m_mode == 0) begin
      if (run) m_mode = 1;
    end else if (m_mode == 1) begin
      if (halt_req) m_mode = 2;
      else if (stall) ;
      else if (!run) m_mode = 0;
      else if (ret) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_err = 1; m_mode = 2; end
      end else if (call) begin
        if (m_stack.size() < 4) begin
          m_stack.push_back((m_pc + 1) % 256);
          m_pc = int'(target);
        end else begin m_err = 1; m_mode = 2; end
      end else if (jump) m_pc = int'(target);
      else m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(im_abus_valid), 32'(m_mode == 1));
    check({tag, ".pc"},    32'(im_abus_data),  32'(m_pc));
    check({tag, ".halted"},32'(halted),        32'(m_mode == 2));
    check({tag, ".err"},   32'(stack_err),     32'(m_err));
    check({tag, ".depth"}, 32'(depth),         32'(m_stack.size()));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 8'h00);
    tick("reset");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 8'h00);
    tick("reset0");
    tick("reset1");
    reset = 1'b0;
    check("rst_valid", 32'(im_abus_valid), 32'd0);
    check("rst_depth", 32'(depth), 32'd0);

    // Free-running increment from 0.
    set_in(1, 0, 0, 0, 0, 0, 8'h00);
    tick("run_start");
    check("first_fetch_pc", 32'(im_abus_data), 32'd0);
    for (int i = 0; i < 4; i++) tick("inc");
    check("inc_pc4", 32'(im_abus_data), 32'd4);

    // Wrap 0xFE -> 0x01.
    set_in(1, 0, 1, 0, 0, 0, 8'hFE);
    tick("jmp_fe");
    set_in(1, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) tick("wrap");
    check("wrap_pc", 32'(im_abus_data), 32'h01);
    check("wrap_err", 32'(stack_err), 32'd0);

    // Call/return pair.
    set_in(1, 0, 1, 0, 0, 0, 8'h10);
    tick("jmp_10");
    set_in(1, 0, 0, 1, 0, 0, 8'h40);
    tick("call_40");
    check("call_pc", 32'(im_abus_data), 32'h40);
    check("call_depth", 32'(depth), 32'd1);
    set_in(1, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) tick("sub_inc");
    set_in(1, 0, 0, 0, 1, 0, 8'h00);
    tick("ret");
    check("ret_pc", 32'(im_abus_data), 32'h11);
    check("ret_depth", 32'(depth), 32'd0);

    // Underflow halts.
    tick("underflow");
    check("uf_halted", 32'(halted), 32'd1);
    check("uf_err", 32'(stack_err), 32'd1);
    set_in(1, 0, 1, 0, 0, 0, 8'h33);
    tick("uf_ignored");
    do_reset();

    // Five nested calls overflow on the fifth.
    set_in(1, 0, 0, 0, 0, 0, 8'h00);
    tick("ov_run");
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 1, 0, 0, 8'(8'h20 + i));
      tick("ov_call");
    end
    check("ov_depth4", 32'(depth), 32'd4);
    set_in(1, 0, 0, 1, 0, 0, 8'h24);
    tick("ov_call5");
    check("ov_halted", 32'(halted), 32'd1);
    check("ov_valid", 32'(im_abus_valid), 32'd0);
    check("ov_pc", 32'(im_abus_data), 32'h23);
    set_in(1, 0, 0, 0, 1, 0, 8'h00);
    tick("ov_ignored");
    set_in(0, 1, 1, 1, 0, 0, 8'h99);
    tick("ov_ignored2");
    check("ov_pc_frozen", 32'(im_abus_data), 32'h23);
    do_reset();
    check("ov_rst_err", 32'(stack_err), 32'd0);

    // Stall drops a jump.
    set_in(1, 0, 0, 0, 0, 0, 8'h00);
    tick("st_run");
    tick("st_inc");
    set_in(1, 1, 1, 0, 0, 0, 8'h80);
    tick("stall0");
    tick("stall1");
    check("stall_pc", 32'(im_abus_data), 32'd1);
    set_in(1, 0, 0, 0, 0, 0, 8'h00);
    tick("stall_rel");
    check("stall_rel_pc", 32'(im_abus_data), 32'd2);

    // Pause and resume at 0x05.
    set_in(1, 0, 1, 0, 0, 0, 8'h05);
    tick("jmp_05");
    set_in(0, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) tick("pause");
    check("pause_valid", 32'(im_abus_valid), 32'd0);
    check("pause_pc", 32'(im_abus_data), 32'h05);
    set_in(1, 0, 0, 0, 0, 0, 8'h00);
    tick("resume");
    check("resume_pc", 32'(im_abus_data), 32'h05);

    // Priority: ret beats call and jump; halt_req beats call.
    set_in(1, 0, 0, 1, 0, 0, 8'h30);
    tick("pr_call");
    set_in(1, 0, 1, 1, 1, 0, 8'h50);
    tick("pr_all");
    check("pr_ret_pc", 32'(im_abus_data), 32'h06);
    check("pr_ret_depth", 32'(depth), 32'd0);
    set_in(1, 0, 0, 1, 0, 0, 8'h60);
    tick("pr_call2");
    set_in(1, 0, 0, 1, 0, 1, 8'h70);
    tick("pr_halt");
    check("pr_halt_depth", 32'(depth), 32'd1);
    check("pr_halt_halted", 32'(halted), 32'd1);
    do_reset();

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(99) < 2);
      set_in($urandom_range(99) < 85, $urandom_range(99) < 15, $urandom_range(99) < 10,
             $urandom_range(99) < 15, $urandom_range(99) < 15, $urandom_range(99) < 1,
             8'($urandom));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-sequencing controller for the instruction memory address bus of simple_cpu. It owns the program counter and computes the next fetch address each cycle from increment, jump, call and return requests. It provides a 4-deep hardware return-address stack, stall/pause handling and a terminal HALT state. It drives the instruction memory address bus and is steered by the decode stage.

Parameters:
AW, 8, program counter / instruction memory address width
STACK_DEPTH, 4, number of return-address stack entries (power of two, ≥2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
run  in  1  level: 1 = fetch enabled, 0 = pause
stall  in  1  freeze PC and ignore all control inputs this cycle
jump  in  1  next PC = target
call  in  1  push PC+1, next PC = target
ret  in  1  next PC = popped return address
halt_req  in  1  enter HALT after this cycle
target  in  AW  jump/call destination
im_abus_valid  out  1  PC on im_abus_data is a valid fetch address
im_abus_data  out  AW  current program counter
halted  out  1  sequencer is in HALT
stack_err  out  1  sticky: stack overflow or underflow occurred
depth  out  clog2(STACK_DEPTH)+1  current stack occupancy

Behaviour:
- Clock and reset: reset is synchronous and active-high; clk is the clock. All state updates on the rising edge of clk.
- Reset values: state=IDLE, PC=0, im_abus_valid=0, halted=0, stack_err=0, depth=0. Reset overrides every other input and also applies from HALT or mid-stall.
- States: IDLE, RUN, HALT. Outputs are registered or decoded from state only, with no combinational path from inputs to outputs.
- IDLE: im_abus_valid=0, PC held. If run=1, go to RUN. The first fetch presents the held PC (0 after reset) one cycle after run is sampled high.
- RUN: im_abus_valid=1, im_abus_data=PC.
  - Per edge, evaluate in this priority order: halt_req > stall > run=0 > ret > call > jump > increment.
  - halt_req=1: go to HALT, PC held.
  - stall=1: PC, stack and state unchanged; jump, call and ret are ignored (not queued).
  - run=0: go to IDLE, PC held. Resume continues from the same PC.
  - ret: if depth>0, PC ← stack[depth-1] and depth decrements. If depth=0 (underflow), stack_err←1, go to HALT, PC held.
  - call: if depth<STACK_DEPTH, push PC+1 (mod 2^AW) then PC ← target, depth increments. If depth=STACK_DEPTH (overflow), stack_err←1, go to HALT, PC held, stack unchanged.
  - jump: PC ← target.
  - Otherwise PC ← PC+1. The increment wraps 2^AW-1 → 0 with no error.
  - Multiple of ret/call/jump asserted together: only the highest-priority one acts.
- HALT: im_abus_valid=0, halted=1, PC frozen, all inputs except reset ignored. Exit only by reset.
- stack_err is cleared only by reset.
- depth reflects occupancy after the edge.
- Latency: a control input sampled at edge N changes im_abus_data after edge N, so it is visible in cycle N+1.
- Stack storage is not cleared on reset; only the pointer is reset.

Test Plan:
- Reset, run=1 held, no controls → im_abus_valid rises 1 cycle after run, im_abus_data = 0,1,2,3… consecutive cycles.
- PC=0xFE, free-running → 0xFE, 0xFF, 0x00, 0x01; stack_err stays 0.
- PC=0x10, call target=0x40 → next PC 0x40, depth=1. Then 3 increments and ret → PC 0x11, depth=0.
- Five nested calls with STACK_DEPTH=4 → first four push OK (depth 4). The fifth sets stack_err=1 and halted=1, im_abus_valid=0, PC frozen at the fifth call site. Further inputs have no effect; reset clears all.
- ret at depth=0 → stack_err=1, HALT. Separately: stall=1 with jump=1 target=0x80 for 2 cycles → PC unchanged; after stall drops, PC increments (jump not queued).
- In RUN at PC=0x05, drop run for 3 cycles → im_abus_valid=0, PC held at 0x05. Reassert run → fetch resumes at 0x05. Separately: call+jump+ret together at depth=1 → ret wins; halt_req with call → HALT, depth unchanged.
